// File: rtl/kernel_sysid_pkg.sv
// kernel_sysid_pkg
// Shared definitions for the system-ID checker: FSM state type, sysid word
// addresses, default expected values (the same constants the sysid slave
// generator uses) and the retry limit used when SYSID_CHECK_RETRY_EN is set.
package kernel_sysid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_ID  = 2'd1,
        ST_RD_TS  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1483621694;

    localparam int unsigned MAX_RETRY = 3;

endpackage

// File: rtl/kernel_sysid_timeout_ctr.sv
// kernel_sysid_timeout_ctr
// Saturating 16-bit waitrequest counter.
// Ports:
//   clock, reset_n - clock, asynchronous active-low reset
//   clr_i          - zero the counter (has priority over en_i)
//   en_i           - count one stalled cycle
//   expired_o      - the current stalled cycle is the last one allowed;
//                    if the stall persists through it, the read is abandoned
module kernel_sysid_timeout_ctr #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // Counter value at which one more stalled cycle reaches LIMIT.
    localparam logic [15:0] LAST = (LIMIT >= 32'd65536) ? 16'hFFFF : 16'(LIMIT - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q >= LAST);

endmodule

// File: rtl/kernel_sysid_checker.sv
// kernel_sysid_checker
// Avalon-MM read master that reads the sysid slave (ID at word 0, timestamp
// at word 1), compares both with build-time values and reports status.
// Optional macro SYSID_CHECK_RETRY_EN: rerun a failing check up to MAX_RETRY
// times and expose retry_count.
// Ports:
//   clock, reset_n          - clock, asynchronous active-low reset
//   start                   - pulse, begins a check when idle
//   av_address, av_read     - Avalon read command (held while stalled)
//   av_readdata, av_waitrequest - Avalon response / stall
//   busy, done              - check in progress / one-cycle completion pulse
//   pass, id_mismatch, ts_mismatch, timeout - sticky status of last check
//   id_value, ts_value      - captured words (0 if never read)
//   retry_count             - retries used (SYSID_CHECK_RETRY_EN only)
module kernel_sysid_checker
    import kernel_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic [31:0] av_readdata,
    input  logic        av_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
`ifdef SYSID_CHECK_RETRY_EN
    ,
    output logic [1:0]  retry_count
`endif
);

    state_e      state_q, state_d;
    logic        first_q;            // set by reset, cleared after the first cycle
    logic        busy_q, busy_d;
    logic        pass_q, pass_d;
    logic        idm_q, idm_d;
    logic        tsm_q, tsm_d;
    logic        to_q, to_d;
    logic [31:0] idv_q, idv_d;
    logic [31:0] tsv_q, tsv_d;
    logic        expired;
    logic        final_w;            // this FINISH ends the check (no retry follows)

`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0]  retry_q, retry_d;
    assign final_w     = pass_q || (retry_q == 2'(MAX_RETRY));
    assign retry_count = retry_q;
`else
    assign final_w = 1'b1;
`endif

    // Command is a pure function of state, so it cannot change while stalled
    // and drops as soon as reset asserts.
    assign av_read    = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
    assign av_address = (state_q == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

    kernel_sysid_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr_i     (!av_read || !av_waitrequest),
        .en_i      (av_read && av_waitrequest),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        pass_d  = pass_q;
        idm_d   = idm_q;
        tsm_d   = tsm_q;
        to_d    = to_q;
        idv_d   = idv_q;
        tsv_d   = tsv_q;
`ifdef SYSID_CHECK_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start || (AUTO_START != 0 && first_q)) begin
                    state_d = ST_RD_ID;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    idm_d   = 1'b0;
                    tsm_d   = 1'b0;
                    to_d    = 1'b0;
                    idv_d   = '0;
                    tsv_d   = '0;
`ifdef SYSID_CHECK_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            ST_RD_ID: begin
                if (!av_waitrequest) begin
                    idv_d   = av_readdata;
                    idm_d   = (av_readdata != EXPECTED_ID);
                    state_d = ST_RD_TS;
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_RD_TS: begin
                if (!av_waitrequest) begin
                    tsv_d   = av_readdata;
                    tsm_d   = (av_readdata != EXPECTED_TS);
                    // Resolve pass on entry to FINISH so it is valid with done.
                    pass_d  = !idm_q && (av_readdata == EXPECTED_TS);
                    state_d = ST_FINISH;
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            default: begin // ST_FINISH
                state_d = ST_IDLE;
                busy_d  = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
                if (!final_w) begin
                    state_d = ST_RD_ID;
                    busy_d  = 1'b1;
                    retry_d = retry_q + 2'd1;
                    idm_d   = 1'b0;
                    tsm_d   = 1'b0;
                    to_d    = 1'b0;
                    idv_d   = '0;
                    tsv_d   = '0;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            first_q <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            idm_q   <= 1'b0;
            tsm_q   <= 1'b0;
            to_q    <= 1'b0;
            idv_q   <= '0;
            tsv_q   <= '0;
`ifdef SYSID_CHECK_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            idm_q   <= idm_d;
            tsm_q   <= tsm_d;
            to_q    <= to_d;
            idv_q   <= idv_d;
            tsv_q   <= tsv_d;
`ifdef SYSID_CHECK_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign done        = (state_q == ST_FINISH) && final_w;
    assign busy        = busy_q;
    assign pass        = pass_q;
    assign id_mismatch = idm_q;
    assign ts_mismatch = tsm_q;
    assign timeout     = to_q;
    assign id_value    = idv_q;
    assign ts_value    = tsv_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Directed bench for kernel_sysid_checker with a combinational sysid slave
// model whose data words and waitrequest are driven step by step.
module tb_kernel_sysid_checker;

    localparam logic [31:0] EXP_TS = 32'd1483621694;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        av_address, av_read, av_waitrequest;
    logic [31:0] av_readdata;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] id_value, ts_value;
    logic [31:0] id_word = 32'h0;
    logic [31:0] ts_word = EXP_TS;
    logic        wr = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0]  retry_count;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    assign av_readdata    = av_address ? ts_word : id_word;
    assign av_waitrequest = wr;

    kernel_sysid_checker #(
        .EXPECTED_ID    (32'h0),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (8),
        .AUTO_START     (1)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .id_mismatch    (id_mismatch),
        .ts_mismatch    (ts_mismatch),
        .timeout        (timeout),
        .id_value       (id_value),
        .ts_value       (ts_value)
`ifdef SYSID_CHECK_RETRY_EN
        ,
        .retry_count    (retry_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge of the RD_ID cycle.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        int dn, rd;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_read", av_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);

        // Auto-start, zero-wait, matching words
        reset_n = 1'b1;
        @(negedge clock);
        chk("a_rdid_read", av_read, 1);
        chk("a_rdid_addr", av_address, 0);
        chk("a_busy", busy, 1);
        chk("a_rdid_done", done, 0);
        @(negedge clock);
        chk("a_rdts_read", av_read, 1);
        chk("a_rdts_addr", av_address, 1);
        @(negedge clock);
        chk("a_fin_read", av_read, 0);
        chk("a_fin_done", done, 1);
        chk("a_pass", pass, 1);
        chk("a_idm", id_mismatch, 0);
        chk("a_tsm", ts_mismatch, 0);
        chk("a_tsv", ts_value, EXP_TS);
        @(negedge clock);
        chk("a_done_end", done, 0);
        chk("a_busy_end", busy, 0);
        chk("a_pass_sticky", pass, 1);

        // ID mismatch
        id_word = 32'h1;
        pulse_start();
        chk("b_pass_clr", pass, 0);
        repeat (2) @(negedge clock);
        chk("b_done", done, 1);
        chk("b_idm", id_mismatch, 1);
        chk("b_tsm", ts_mismatch, 0);
        chk("b_pass", pass, 0);
        chk("b_idv", id_value, 32'h1);
        id_word = 32'h0;
        @(negedge clock);

        // Five-cycle stall on the timestamp read
        pulse_start();
        @(negedge clock);
        wr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("c_stall_read", av_read, 1);
            chk("c_stall_addr", av_address, 1);
            @(negedge clock);
        end
        wr = 1'b0;
        @(negedge clock);
        chk("c_done", done, 1);
        chk("c_pass", pass, 1);
        chk("c_tsv", ts_value, EXP_TS);
        chk("c_to", timeout, 0);
        @(negedge clock);

        // Stuck waitrequest: 8 stalled reads, then timeout
        id_word = 32'h1;
        wr = 1'b1;
        pulse_start();
        dn = 0;
        rd = 0;
        for (int k = 0; k < 12; k++) begin
            dn += int'(done);
            rd += int'(av_read);
            if (k == 8) chk("d_done_at9", done, 1);
            @(negedge clock);
        end
        wr = 1'b0;
        chk("d_done_cnt", dn, 1);
        chk("d_read_cnt", rd, 8);
        chk("d_to", timeout, 1);
        chk("d_pass", pass, 0);
        chk("d_idv", id_value, 0);
        chk("d_tsv", ts_value, 0);
        id_word = 32'h0;

        // start while busy and in the done cycle is ignored
        pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("e_done", done, 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("e_idle_busy", busy, 0);
        chk("e_idle_read", av_read, 0);
        @(negedge clock);
        chk("e_no_rerun", busy, 0);

        // Reset mid-RD_TS
        id_word = 32'h55;
        pulse_start();
        @(negedge clock);
        wr = 1'b1;
        chk("f_rdts_read", av_read, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("f_rst_read", av_read, 0);
        chk("f_rst_idm", id_mismatch, 0);
        chk("f_rst_idv", id_value, 0);
        chk("f_rst_busy", busy, 0);
        @(negedge clock);
        id_word = 32'h0;
        wr = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("f_rerun_done", done, 1);
        chk("f_rerun_pass", pass, 1);
        @(negedge clock);

`ifdef SYSID_CHECK_RETRY_EN
        // Timestamp wrong on the first two attempts
        ts_word = 32'hBAD0_BAD0;
        pulse_start();
        dn = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 7) ts_word = EXP_TS;
            dn += int'(done);
            @(negedge clock);
        end
        chk("g_done_cnt", dn, 1);
        chk("g_retry", retry_count, 2);
        chk("g_pass", pass, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
